seq_divider_4bit: RTL and testbench
===================================

Name: seq_divider_4bit

Overview:
- Iterative restoring unsigned divider; the inverse-operation companion to the team's array/Wallace multipliers.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock.
- Uses a start/busy/done handshake so a controller or datapath sequencer can issue operations and collect results.
- Results are reusable to check multiplier outputs: q*b + r == a.

Parameters:
- WIDTH, 4, operand width in bits; legal values 2..16.
- CNT_W, $clog2(WIDTH+1), width of the internal step counter; derived, not overridden.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- dividend  input  WIDTH  a; captured on an accepted start.
- divisor  input  WIDTH  b; captured on an accepted start.
- busy  output  1  high from the accept edge until the edge that raises done.
- done  output  1  one-cycle pulse; quotient/remainder valid.
- quotient  output  WIDTH  a / b.
- remainder  output  WIDTH  a % b.
- div_by_zero  output  1  set with done when b==0; held with the results.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE; busy, done, div_by_zero=0; quotient, remainder=0; internal registers=0.
- States:
  - IDLE: busy=0.
  - CALC: busy=1, one restoring step per edge.
  - DONE: done=1 for exactly one cycle, busy=0.
- Transitions:
  - IDLE->CALC on start with b!=0.
  - IDLE->DONE on start with b==0.
  - CALC->DONE after WIDTH steps.
  - DONE->IDLE unconditionally.
- Accept edge:
  - Latch a into the shift register and b into the divisor register.
  - Clear the partial remainder and counter.
  - Clear div_by_zero.
- Step:
  - rem_shift = {partial_rem, msb of shift reg}, WIDTH+1 bits.
  - diff = rem_shift - {0,b}.
  - If diff is non-negative (borrow=0): partial_rem=diff, quotient bit=1.
  - Otherwise keep rem_shift and set the quotient bit to 0.
  - Shift the quotient bit into the LSB of the shift register.
  - Counter increments.
- Latency: done is high in the cycle after edge (accept+WIDTH); 4 cycles after the accept edge for WIDTH=4.
- Divide by zero:
  - done is high the cycle after the accept edge.
  - quotient = all ones, remainder = a, div_by_zero = 1.
- Outputs quotient, remainder and div_by_zero hold their last values until the next accepted start. They are never cleared by DONE->IDLE.
- start while busy=1 or in DONE is ignored, with no queuing. start in the same cycle that done is high is ignored; it is accepted only from IDLE.
- a < b: quotient=0, remainder=a. a == 0: quotient=0, remainder=0. Both use the normal WIDTH-cycle latency.
- Reset mid-CALC:
  - Aborts immediately and all outputs go to reset values.
  - No done pulse for the aborted operation.
- Inputs dividend/divisor may change freely after the accept edge without affecting the result.

Decomposition:
- Shared package div_pkg holds:
  - state typedef div_state_t {IDLE, CALC, DONE};
  - localparam DEF_WIDTH=4.
- One natural sub-module, div_step: combinational conditional subtractor.
  - Inputs: WIDTH+1-bit rem_shift and WIDTH-bit divisor.
  - Outputs: next remainder and quotient bit.
  - Parameterised by WIDTH, reusable by a future unrolled/pipelined divider.
- The top module holds the FSM, counter and registers.

Test Plan:
- a=13, b=3, start 1 cycle -> busy high 4 cycles; done pulse the cycle after edge accept+4; quotient=4, remainder=1, div_by_zero=0.
- a=15,b=1 -> q=15,r=0. a=0,b=7 -> q=0,r=0. a=5,b=9 -> q=0,r=5. Each with 4-cycle latency.
- a=9, b=0 -> done the cycle after accept; q=4'b1111, r=9, div_by_zero=1. Next op a=8,b=2 -> div_by_zero cleared, q=4, r=0.
- start held high continuously with new operands each cycle -> each op accepted only from IDLE; exactly one done per accepted op; results match the operands latched at the accept edge.
- rst_n pulsed low at step 2 of a=14,b=3 -> outputs zero, no done. After release, a=14,b=3 -> q=4, r=2.
- Exhaustive sweep of all 256 (a,b) pairs back-to-back -> q*b+r==a and r<b for b!=0; b==0 cases are as specified. Scoreboard checks done count == accepted start count.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared types and defaults for the sequential divider family.
package div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
    localparam int DEF_WIDTH = 4;
endpackage

// File: rtl/seq_divider_4bit_if.sv
// seq_divider_4bit_if: start/busy/done handshake and operand/result bus.
interface seq_divider_4bit_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// div_step: one restoring-division step (conditional subtract of the divisor).
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_shift,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    // When the subtract succeeds the true difference is below divisor, so WIDTH bits suffice.
    logic [WIDTH-1:0] diff;
    assign q_bit    = rem_shift >= {1'b0, divisor};
    assign diff     = rem_shift[WIDTH-1:0] - divisor;
    assign rem_next = q_bit ? diff : rem_shift[WIDTH-1:0];
endmodule

// File: rtl/seq_divider_4bit.sv
// seq_divider_4bit: iterative restoring unsigned divider, one quotient bit per clock.
module seq_divider_4bit
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic clk,
    input logic rst_n,
    seq_divider_4bit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shift_reg, div_reg, part_rem, rem_nxt, quo_r, rem_r;
    logic             q_bit, dbz_r, accept, last_step, zero_div;

    assign zero_div  = bus.divisor == '0;
    assign accept    = state == IDLE && bus.start;
    assign last_step = cnt == CNT_W'(WIDTH - 1);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_shift ({part_rem, shift_reg[WIDTH-1]}),
        .divisor   (div_reg),
        .rem_next  (rem_nxt),
        .q_bit     (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.start ? (zero_div ? DONE : CALC) : IDLE;
            CALC:    state_nxt = last_step ? DONE : CALC;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Divide-by-zero results are produced on the accept edge itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            shift_reg <= '0;
            div_reg   <= '0;
            part_rem  <= '0;
            quo_r     <= '0;
            rem_r     <= '0;
            dbz_r     <= 1'b0;
        end else if (accept) begin
            cnt       <= '0;
            shift_reg <= bus.dividend;
            div_reg   <= bus.divisor;
            part_rem  <= '0;
            dbz_r     <= zero_div;
            if (zero_div) begin
                quo_r <= '1;
                rem_r <= bus.dividend;
            end
        end else if (state == CALC) begin
            cnt       <= cnt + 1'b1;
            shift_reg <= {shift_reg[WIDTH-2:0], q_bit};
            part_rem  <= rem_nxt;
            if (last_step) begin
                quo_r <= {shift_reg[WIDTH-2:0], q_bit};
                rem_r <= rem_nxt;
            end
        end
    end

    assign bus.busy        = state == CALC;
    assign bus.done        = state == DONE;
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider_4bit.sv
// tb_seq_divider_4bit: scoreboard bench with a cycle model of the handshake.
module tb_seq_divider_4bit;
    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a, b, q, r;
        logic         dbz;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0, passed = 0;
    int   acc_cnt = 0, done_cnt = 0;
    exp_t sb[$];
    bit   m_busy = 0, m_done = 0, m_dbz = 0;
    int   m_cnt = 0;
    logic [W-1:0] exp_q = '0, exp_r = '0;

    seq_divider_4bit_if #(.WIDTH(W)) bus ();

    seq_divider_4bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        e.q = (b == 0) ? '1 : a / b;
        e.r = (b == 0) ? a : a % b;
        e.dbz = (b == 0);
        return e;
    endfunction

    // Reference timing: accept only from idle, W steps, one-cycle done.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt -= sb.size();
            sb.delete();
            m_busy = 0;
            m_done = 0;
            m_cnt  = 0;
            m_dbz  = 0;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == W) begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (bus.start) begin
            sb.push_back(model(bus.dividend, bus.divisor));
            acc_cnt++;
            m_dbz = (bus.divisor == 0);
            if (bus.divisor == 0) m_done = 1;
            else begin
                m_busy = 1;
                m_cnt  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q = '0;
            exp_r = '0;
        end else begin
            total++;
            if ({bus.busy, bus.done} !== {m_busy, m_done})
                $display("FAIL handshake t=%0t busy/done=%b%b expected %b%b", $time, bus.busy, bus.done, m_busy, m_done);
            else passed++;
            if (bus.done) begin
                done_cnt++;
                total++;
                if (sb.size() == 0)
                    $display("FAIL sb_empty t=%0t done with no accepted op", $time);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    exp_q = e.q;
                    exp_r = e.r;
                    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dbz})
                        $display("FAIL result a=%0d b=%0d got q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=%b",
                                 e.a, e.b, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
                    else passed++;
                    if (!e.dbz) begin
                        total++;
                        if ((8'(bus.quotient) * 8'(e.b) + 8'(bus.remainder) !== 8'(e.a)) || !(bus.remainder < e.b))
                            $display("FAIL identity a=%0d b=%0d got q=%0d r=%0d expected q*b+r==a and r<b",
                                     e.a, e.b, bus.quotient, bus.remainder);
                        else passed++;
                    end
                end
            end
            total++;
            if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {exp_q, exp_r, m_dbz})
                $display("FAIL hold t=%0t got q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=%b",
                         $time, bus.quotient, bus.remainder, bus.div_by_zero, exp_q, exp_r, m_dbz);
            else passed++;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!m_busy && !m_done) return;
        end
        total++;
        $display("FAIL idle_timeout t=%0t busy=%b done=%b expected idle", $time, bus.busy, bus.done);
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
        wait_idle();
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = $urandom_range(0, 15);
        bus.divisor  = $urandom_range(0, 15);
    endtask

    task automatic op_chk(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                          input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        int n = 0;
        drive(a, b);
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n !== lat) $display("FAIL latency a=%0d b=%0d got %0d expected %0d", a, b, n, lat);
        else passed++;
        total++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {q, r, dbz})
            $display("FAIL op a=%0d b=%0d got q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=%b",
                     a, b, bus.quotient, bus.remainder, bus.div_by_zero, q, r, dbz);
        else passed++;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0)
            $display("FAIL reset got busy=%b done=%b q=%0d r=%0d dbz=%b expected all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        else passed++;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        op_chk(13, 3, 4, 4, 1, 0);
    endtask

    task automatic test_corners();
        op_chk(15, 1, 4, 15, 0, 0);
        op_chk(0, 7, 4, 0, 0, 0);
        op_chk(5, 9, 4, 0, 5, 0);
        op_chk(9, 0, 0, 4'hF, 9, 1);
        op_chk(8, 2, 4, 4, 0, 0);
    endtask

    task automatic test_back_to_back();
        wait_idle();
        bus.start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            bus.dividend = $urandom_range(0, 15);
            bus.divisor  = (i % 7 == 3) ? 4'd0 : 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        bus.start = 1'b0;
        wait_idle();
        total++;
        if (done_cnt !== acc_cnt) $display("FAIL b2b_count got %0d dones expected %0d", done_cnt, acc_cnt);
        else passed++;
    endtask

    task automatic test_reset_abort();
        int d0;
        drive(14, 3);
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0)
            $display("FAIL abort got busy=%b done=%b q=%0d r=%0d dbz=%b expected all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        else passed++;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        total++;
        if (done_cnt !== d0) $display("FAIL abort_done got %0d dones expected %0d", done_cnt, d0);
        else passed++;
        op_chk(14, 3, 4, 4, 2, 0);
    endtask

    task automatic test_sweep();
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                drive(4'(a), 4'(b));
        wait_idle();
        total++;
        if (done_cnt !== acc_cnt || sb.size() != 0)
            $display("FAIL sweep_count got %0d dones, %0d pending expected %0d dones, 0 pending",
                     done_cnt, sb.size(), acc_cnt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
